// File: rtl/vram_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vram_pkg
// Purpose  : Shared constants and state type for the video-RAM write-port
//            arbiter (1024 x 18 dual-port RAM, write port A).
// Contents : ADDR_W / DATA_W / DEPTH geometry, last clear address, state_t.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;
    // Words swept by the clear engine; the sweep covers the whole address
    // space, so this must equal 2**ADDR_W.
    localparam int DEPTH  = 1024;

    // Address of the final clear write; the engine leaves CLEAR after it.
    localparam logic [ADDR_W-1:0] C_LAST_AD = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : vram_write_arbiter_if
// Purpose   : Bundles the two requester handshakes, the clear-engine control
//             and the RAM write-port outputs of vram_write_arbiter.
// Modports  : master - requester / controller side (drives valids, addresses,
//                      data, clear_start, clear_data)
//             slave  - arbiter side (drives readies, clear status, RAM port)
// Revision  : 1.0 - initial release
// ============================================================================
interface vram_write_arbiter_if;
    import vram_pkg::*;

    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    // Clear engine
    logic              clear_start;
    logic [DATA_W-1:0] clear_data;
    logic              clear_busy;
    logic              clear_done;

    // RAM write port A
    logic              ram_ce;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output clear_start, clear_data,
        input  clear_busy, clear_done,
        input  ram_ce, ram_ad, ram_data
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  clear_start, clear_data,
        output clear_busy, clear_done,
        output ram_ce, ram_ad, ram_data
    );

endinterface
`default_nettype wire

// File: rtl/vram_write_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter with the priority pointer inside.
//            After a grant to requester N the pointer moves to 1-N, so two
//            continuously valid requesters alternate; a lone requester is
//            granted every cycle regardless of the pointer.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset (pointer -> 0)
//            i_en     - arbitration enable; no ready/grant while low
//            i_valid  - request valids [1:0]
//            o_ready  - per-requester ready (independent of own valid)
//            o_grant  - per-requester grant (ready & valid), one-hot or zero
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic [1:0] i_valid,
    output logic      [1:0] o_ready,
    output logic      [1:0] o_grant
);

    // r_ptr names the requester that wins when both are valid.
    logic r_ptr;

    always_comb begin
        o_ready = 2'b00;
        if (i_en) begin
            o_ready[0] = ~i_valid[1] | ~r_ptr;
            o_ready[1] = ~i_valid[0] |  r_ptr;
        end
        o_grant = o_ready & i_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (o_grant[0]) begin
            r_ptr <= 1'b1;
        end else if (o_grant[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_arbiter
// Purpose  : Shares write port A of the 1024 x 18 video RAM between two
//            valid/ready requesters (round-robin) and a screen-clear engine
//            that fills every word with one value at one word per cycle.
//            RAM port signals are registered: an accepted beat appears on
//            ram_ce/ram_ad/ram_data for exactly one cycle, the cycle after
//            acceptance.
// Ports    : clk    - single clock (logic and RAM write port)
//            reset  - synchronous active-high reset
//            bus    - vram_write_arbiter_if.slave:
//                       req0_*/req1_* valid/ready/addr/data handshakes
//                       clear_start/clear_data in, clear_busy/clear_done out
//                       ram_ce/ram_ad/ram_data to the RAM write port
// Revision : 1.0 - initial release
// ============================================================================
module vram_write_arbiter
    import vram_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           reset,
    vram_write_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // State, counter, latched fill value and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_clr_data;
    logic [DATA_W-1:0] w_clr_data_nxt;

    logic              r_ram_ce;
    logic [ADDR_W-1:0] r_ram_ad;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_clear_busy;
    logic              r_clear_done;

    logic              w_ram_ce_nxt;
    logic [ADDR_W-1:0] w_ram_ad_nxt;
    logic [DATA_W-1:0] w_ram_data_nxt;
    logic              w_clear_busy_nxt;
    logic              w_clear_done_nxt;

    // ------------------------------------------------------------------
    // Requester arbitration. A clear request in ARB takes the whole cycle,
    // so arbitration is disabled then as well as throughout CLEAR.
    // ------------------------------------------------------------------
    logic       w_arb_en;
    logic [1:0] w_valid;
    logic [1:0] w_ready;
    logic [1:0] w_grant;

    assign w_arb_en = (r_state == ARB) && !bus.clear_start;
    assign w_valid  = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_arb_en),
        .i_valid (w_valid),
        .o_ready (w_ready),
        .o_grant (w_grant)
    );

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];

    // ------------------------------------------------------------------
    // Next-state and next-output logic. The output registers are loaded
    // with what the RAM must see in the following cycle, so the clear
    // counter always equals the address currently on ram_ad during CLEAR.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_clr_data_nxt   = r_clr_data;
        w_ram_ce_nxt     = 1'b0;
        w_ram_ad_nxt     = r_ram_ad;
        w_ram_data_nxt   = r_ram_data;
        w_clear_busy_nxt = 1'b0;
        w_clear_done_nxt = 1'b0;

        case (r_state)
            ARB: begin
                if (bus.clear_start) begin
                    // First clear write (address 0) goes out next cycle.
                    w_state_nxt      = CLEAR;
                    w_clr_cnt_nxt    = '0;
                    w_clr_data_nxt   = bus.clear_data;
                    w_ram_ce_nxt     = 1'b1;
                    w_ram_ad_nxt     = '0;
                    w_ram_data_nxt   = bus.clear_data;
                    w_clear_busy_nxt = 1'b1;
                    w_clear_done_nxt = (C_LAST_AD == '0);
                end else if (w_grant[0]) begin
                    w_ram_ce_nxt   = 1'b1;
                    w_ram_ad_nxt   = bus.req0_addr;
                    w_ram_data_nxt = bus.req0_data;
                end else if (w_grant[1]) begin
                    w_ram_ce_nxt   = 1'b1;
                    w_ram_ad_nxt   = bus.req1_addr;
                    w_ram_data_nxt = bus.req1_data;
                end
            end

            CLEAR: begin
                // clear_start is deliberately not looked at here: a running
                // sweep cannot be restarted.
                if (r_clr_cnt != C_LAST_AD) begin
                    w_clr_cnt_nxt    = r_clr_cnt + 1'b1;
                    w_ram_ce_nxt     = 1'b1;
                    w_ram_ad_nxt     = w_clr_cnt_nxt;
                    w_ram_data_nxt   = r_clr_data;
                    w_clear_busy_nxt = 1'b1;
                    w_clear_done_nxt = (w_clr_cnt_nxt == C_LAST_AD);
                end else begin
                    // Last word is on the RAM port now; arbitration resumes
                    // next cycle with no write in it.
                    w_state_nxt = ARB;
                end
            end

            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_clr_cnt    <= '0;
            r_clr_data   <= '0;
            r_ram_ce     <= 1'b0;
            r_ram_ad     <= '0;
            r_ram_data   <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_clr_data   <= w_clr_data_nxt;
            r_ram_ce     <= w_ram_ce_nxt;
            r_ram_ad     <= w_ram_ad_nxt;
            r_ram_data   <= w_ram_data_nxt;
            r_clear_busy <= w_clear_busy_nxt;
            r_clear_done <= w_clear_done_nxt;
        end
    end

    assign bus.ram_ce     = r_ram_ce;
    assign bus.ram_ad     = r_ram_ad;
    assign bus.ram_data   = r_ram_data;
    assign bus.clear_busy = r_clear_busy;
    assign bus.clear_done = r_clear_done;

endmodule
`default_nettype wire

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Shares the single write port (port A) of the 1024x18 dual-port video RAM between two write requesters and a built-in screen-clear engine.
- Requesters use valid/ready handshakes and are served round-robin.
- The clear engine fills every word with a given value at one word per cycle.
- Outputs register directly into the RAM's write_ce/write_ad/write_data. The RAM write clock is the same clk; WREA is tied high at the RAM.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 18, RAM word width.
- DEPTH, 1024, words cleared by the clear engine; must equal 2**ADDR_W.

Ports:
- clk  in  1  Single clock for all logic and the RAM write port.
- reset  in  1  Synchronous, active-high reset.
- req0_valid  in  1  Requester 0 has a write pending.
- req0_ready  out  1  Requester 0 write accepted this cycle (when valid).
- req0_addr  in  ADDR_W  Requester 0 word address.
- req0_data  in  DATA_W  Requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1.
- clear_start  in  1  Single-cycle pulse; starts a full-RAM clear.
- clear_data  in  DATA_W  Fill value; sampled in the clear_start cycle.
- clear_busy  out  1  Clear in progress.
- clear_done  out  1  One-cycle pulse on the final clear write.
- ram_ce  out  1  To the RAM write_ce.
- ram_ad  out  ADDR_W  To the RAM write_ad.
- ram_data  out  DATA_W  To the RAM write_data.

Behaviour:
- Reset values (applied on the clk edge where reset=1):
  - state=ARB, rr pointer=0.
  - ram_ce=0, ram_ad=0, ram_data=0.
  - clear_busy=0, clear_done=0.
  - No RAM write occurs in the cycle after reset.
- State ARB, ready logic (combinational from state, valids, pointer, clear_start):
  - reqN_ready=1 when state==ARB, clear_start==0, and either the other requester is not valid or the pointer==N.
  - Readies are never high in the CLEAR state.
- Handshake:
  - A beat is accepted when valid and ready are both high.
  - A requester holds valid, addr and data stable until accepted.
  - Valid must not be withdrawn before acceptance.
- Latency:
  - An accepted beat appears on ram_ce=1 / ram_ad / ram_data on the next cycle, for exactly one cycle.
  - With no acceptance, ram_ce=0 and ram_ad/ram_data hold their previous values.
- Round-robin:
  - After any grant to N, the pointer becomes 1-N.
  - Both requesters continuously valid therefore alternate 0,1,0,1 (from pointer 0), with one write per cycle.
  - A lone requester gets back-to-back grants regardless of the pointer.
- Throughput: 1 write per cycle maximum.
- Clear start (clear_start=1 in ARB):
  - Wins over same-cycle requests; both readies are 0 that cycle.
  - clear_data is latched.
  - Next state is CLEAR with counter=0.
- State CLEAR, every cycle:
  - ram_ce=1, ram_ad=counter, ram_data=latched value, clear_busy=1.
  - counter increments.
- Clear timing:
  - The first clear write (ram_ad=0) occurs in the cycle after clear_start.
  - The last write (ram_ad=DEPTH-1) occurs DEPTH cycles after clear_start.
  - clear_done=1 coincides with that last write.
  - The following cycle: state=ARB, clear_busy=0, readies re-evaluated.
- During CLEAR, clear_start is ignored (no restart). Counter wrap is impossible: the state exits at DEPTH-1.
- Write collisions: a write to the same address from one requester in consecutive beats is legal. Order is preserved because there is one write per cycle in grant order.
- Reset mid-clear:
  - Aborts immediately; next cycle ram_ce=0, clear_busy=0, no clear_done.
  - Partially cleared contents remain in the RAM.
- Reset mid-handshake: a pending (unaccepted) request is not written; the requester re-presents it after reset.

Decomposition:
- Package vram_pkg holds:
  - ADDR_W=10, DATA_W=18, DEPTH=1024 constants.
  - The state enum (ARB, CLEAR).
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs are the valids and an enable; outputs are grants, with the pointer flop inside.
- Top level holds the clear counter, the state, and the output registers.

Test Plan:
- Reset, then idle: with reset high 2 cycles then low and no valids, ram_ce stays 0 and ram_ad=0, ram_data=0.
- Single write: req0 with addr=0x123, data=0x2AAAA, held valid. req0_ready=1 in the same cycle; the next cycle shows ram_ce=1, ram_ad=0x123, ram_data=0x2AAAA; the cycle after, ram_ce=0.
- Contention: both valid for 4 beats with distinct addresses 0x010-0x013 (req0) and 0x020-0x023 (req1). Grants alternate 0,1,0,1...; the RAM sees 0x010, 0x020, 0x011, 0x021 on consecutive cycles with no idle cycle.
- Clear: clear_start with clear_data=0x00020 and req1 valid in the same cycle. req1_ready=0; ram_ad sweeps 0..1023 over 1024 consecutive cycles with data 0x00020. clear_done occurs only at ad=1023, then req1 is accepted the following cycle.
- Clear restart ignored: a second clear_start at ad=500 produces no change in the sweep, exactly one clear_done, and 1024 total writes.
- Reset mid-clear: reset at ad=300 gives ram_ce=0 and clear_busy=0 on the next cycle, with no clear_done. A subsequent req0 write is served normally with pointer=0 behaviour.
